wallace_final_cpa: RTL and testbench

//   Final carry-propagate adder of the pipelined 32x32 Wallace multiplier.
//   - Sits directly downstream of the level-7 reduction register.
//   - Consumes the last two 65-bit rows (sum, carry) and produces the 64-bit product.
//   - Two-stage pipelined adder, split at SPLIT, with a valid/ready handshake so the

---
 rtl/wallace_final_cpa_if.sv | 25 ++
 rtl/wallace_final_cpa.sv | 110 +++++++++++
 tb/tb_wallace_final_cpa.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wallace_final_cpa_if.sv
// rtl/wallace_final_cpa_if.sv - row-pair input and product output handshake bundle
// master drives rows and out_ready; slave is the adder side.
interface wallace_final_cpa_if #(
  parameter int W     = 65,
  parameter int OUT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     sum_row;
  logic [W-1:0]     carry_row;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] prod;
  logic             out_ovf;

  modport master (
    output in_valid, sum_row, carry_row, out_ready,
    input  in_ready, out_valid, prod, out_ovf
  );

  modport slave (
    input  in_valid, sum_row, carry_row, out_ready,
    output in_ready, out_valid, prod, out_ovf
  );
endinterface

// File: rtl/wallace_final_cpa.sv
// rtl/wallace_final_cpa.sv - two-stage split carry-propagate adder closing the Wallace multiplier
// WALLACE_CPA_OVF_EN builds the weight >= 2^OUT_W overflow flag; otherwise out_ovf is 0.
module wallace_final_cpa #(
  parameter int W     = 65,
  parameter int SPLIT = 32,
  parameter int OUT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  wallace_final_cpa_if.slave bus
);
  localparam int HI_W = W - SPLIT;
  localparam int PH_W = OUT_W - SPLIT;

  logic             va_q, va_d;
  logic             vb_q, vb_d;
  logic [SPLIT-1:0] lo_sum_q, lo_sum_d;
  logic             ca_q, ca_d;
  logic [HI_W-1:0]  hi_s_q, hi_s_d;
  logic [HI_W-1:0]  hi_c_q, hi_c_d;
  logic [OUT_W-1:0] prod_q, prod_d;
  logic             ovf_q, ovf_d;

  logic             ld_a, ld_b;
  logic [SPLIT:0]   lo_add;
  logic [PH_W-1:0]  hi_prod;
  logic             ovf_next;

  // Stage B frees up when empty or draining; stage A rides on B's slot.
  assign ld_b         = !vb_q || bus.out_ready;
  assign ld_a         = !va_q || ld_b;
  assign bus.in_ready = ld_a && !rst;

  assign lo_add = {1'b0, bus.sum_row[SPLIT-1:0]} + {1'b0, bus.carry_row[SPLIT-1:0]};

`ifdef WALLACE_CPA_OVF_EN
  logic [HI_W:0] hi_add;

  assign hi_add   = {1'b0, hi_s_q} + {1'b0, hi_c_q} + {{HI_W{1'b0}}, ca_q};
  assign hi_prod  = hi_add[PH_W-1:0];
  assign ovf_next = |hi_add[HI_W:PH_W];
`else
  logic [HI_W-PH_W-1:0] unused_hi_s;
  logic [HI_W-PH_W-1:0] unused_hi_c;

  // Only the product-visible high bits are summed; the carry-out is never formed.
  assign hi_prod     = hi_s_q[PH_W-1:0] + hi_c_q[PH_W-1:0] + {{(PH_W-1){1'b0}}, ca_q};
  assign unused_hi_s = hi_s_q[HI_W-1:PH_W];
  assign unused_hi_c = hi_c_q[HI_W-1:PH_W];
  assign ovf_next    = 1'b0;
`endif

  always_comb begin
    va_d     = va_q;
    lo_sum_d = lo_sum_q;
    ca_d     = ca_q;
    hi_s_d   = hi_s_q;
    hi_c_d   = hi_c_q;
    if (ld_a) begin
      va_d = bus.in_valid;
      if (bus.in_valid) begin
        lo_sum_d = lo_add[SPLIT-1:0];
        ca_d     = lo_add[SPLIT];
        hi_s_d   = bus.sum_row[W-1:SPLIT];
        hi_c_d   = bus.carry_row[W-1:SPLIT];
      end
    end
    if (rst) begin
      va_d     = 1'b0;
      lo_sum_d = '0;
      ca_d     = 1'b0;
      hi_s_d   = '0;
      hi_c_d   = '0;
    end
  end

  always_comb begin
    vb_d   = vb_q;
    prod_d = prod_q;
    ovf_d  = ovf_q;
    if (ld_b) begin
      vb_d = va_q;
      // A bubble advancing into B leaves the last product untouched.
      if (va_q) begin
        prod_d = {hi_prod, lo_sum_q};
        ovf_d  = ovf_next;
      end
    end
    if (rst) begin
      vb_d   = 1'b0;
      prod_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    va_q     <= va_d;
    lo_sum_q <= lo_sum_d;
    ca_q     <= ca_d;
    hi_s_q   <= hi_s_d;
    hi_c_q   <= hi_c_d;
    vb_q     <= vb_d;
    prod_q   <= prod_d;
    ovf_q    <= ovf_d;
  end

  assign bus.out_valid = vb_q;
  assign bus.prod      = prod_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_wallace_final_cpa.sv
// tb/tb_wallace_final_cpa.sv - scoreboard bench for wallace_final_cpa
// Honours WALLACE_CPA_OVF_EN for the expected out_ovf.
module tb_wallace_final_cpa;
  localparam int W     = 65;
  localparam int SPLIT = 32;
  localparam int OUT_W = 64;
`ifdef WALLACE_CPA_OVF_EN
  localparam bit OVF_EXP = 1'b1;
`else
  localparam bit OVF_EXP = 1'b0;
`endif

  typedef struct {
    logic [OUT_W-1:0] prod;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst;
  wallace_final_cpa_if #(.W(W), .OUT_W(OUT_W)) bus ();

  wallace_final_cpa #(.W(W), .SPLIT(SPLIT), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_fire = 0;
  int   first_fire = -1;
  int   last_fire = -1;
  logic [OUT_W-1:0] held;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Samples the handshake at negedge, then returns just after the next posedge.
  task automatic tick();
    logic [W:0] full;
    exp_t       e;
    @(negedge clk);
    cyc++;
    if (bus.out_valid && bus.out_ready) begin
      chk("out_expected", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("prod", bus.prod, e.prod);
        chk("out_ovf", bus.out_ovf, e.ovf);
      end
      n_fire++;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
    end
    if (bus.in_valid && bus.in_ready) begin
      full   = {1'b0, bus.sum_row} + {1'b0, bus.carry_row};
      e.prod = full[OUT_W-1:0];
      e.ovf  = OVF_EXP ? (|full[W:OUT_W]) : 1'b0;
      sb.push_back(e);
      n_push++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] s, input logic [W-1:0] c);
    bus.in_valid  = 1'b1;
    bus.sum_row   = s;
    bus.carry_row = c;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12 && sb.size() > 0; k++) tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [W-1:0] rnd_row();
    return {$urandom_range(0, 1) == 1, $urandom(), $urandom()};
  endfunction

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sum_row   = 65'h5;
    bus.carry_row = 65'h7;
    bus.out_ready = 1'b1;

    // Reset held with in_valid high
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_prod", bus.prod, '0);
      chk("rst_ovf", bus.out_ovf, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("release_in_ready", bus.in_ready, 1'b1);

    // Carry across the split boundary, with latency
    drive(65'h0_FFFF_FFFF, 65'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("lat_cycle1", bus.out_valid, 1'b0);
    tick();
    chk("lat_cycle2", bus.out_valid, 1'b1);
    chk("split_prod", bus.prod, 66'h0000_0001_0000_0000);
    chk("split_ovf", bus.out_ovf, 1'b0);
    drain();

    // Streaming back-to-back
    n_fire = 0; first_fire = -1; last_fire = -1;
    for (int i = 1; i <= 8; i++) begin
      drive(65'(i), 65'(i) << 33);
      chk("stream_in_ready", bus.in_ready, 1'b1);
      tick();
    end
    drain();
    chk("stream_count", n_fire, 8);
    chk("stream_contig", last_fire - first_fire, 7);

    // Back-pressure: only two slots
    n_push = 0; n_fire = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(rnd_row(), rnd_row());
      tick();
    end
    chk("bp_accepted", n_push, 2);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_out_valid", bus.out_valid, 1'b1);
    chk("bp_front", bus.prod, sb[0].prod);
    held = bus.prod;
    tick();
    chk("bp_hold", bus.prod, held);
    drain();
    chk("bp_drained", n_fire, 2);

    // Random valid/ready mix
    for (int k = 0; k < 40; k++) begin
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.sum_row   = rnd_row();
      bus.carry_row = rnd_row();
      bus.out_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    drain();

    // Reset while two results are in flight
    n_push = 0;
    bus.out_ready = 1'b0;
    drive(65'h123, 65'h456);
    tick();
    drive(65'h789, 65'hABC);
    tick();
    chk("mid_accepted", n_push, 2);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    sb.delete();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid_no_output", bus.out_valid, 1'b0);
    end

    // Overflow past 2^64
    drive(65'h0_FFFF_FFFF_FFFF_FFFF, 65'h1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("ovf_valid", bus.out_valid, 1'b1);
    chk("ovf_prod", bus.prod, '0);
    chk("ovf_flag", bus.out_ovf, OVF_EXP);
    drain();
    drive(65'h1_0000_0000_0000_0005, 65'h3);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
